// File: rtl/blc_line_feeder_if.sv
// Handshake bundle between the sensor, the line feeder and the black-level-correction stage.
// master: the side driving sensor pixels and the correction-stage idle level; slave: the feeder.
interface blc_line_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  m_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/blc_line_feeder.sv
// Buffers sensor pixels and releases one whole line per burst to the black-level-correction stage.
// Optional watchdog on the post-burst handshake: define BLC_LINE_FEEDER_TIMEOUT_EN.
module blc_line_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_LEN   = 36,
  parameter int FIFO_DEPTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  blc_line_feeder_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(LINE_LEN);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic [CW-1:0]         beat;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic wr_en, rd_en, start, last_beat;

  assign bus.s_ready = (level < LW'(FIFO_DEPTH));
  assign wr_en       = bus.s_valid && bus.s_ready;
  // A burst only starts with a full line buffered, so popping every BURST cycle cannot underflow.
  assign rd_en       = (state == BURST);
  assign start       = (level >= LW'(LINE_LEN)) && bus.m_ready;
  assign last_beat   = (beat == CW'(LINE_LEN - 1));

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign fifo_level  = level;
  assign busy        = (state != IDLE);

  // NOTE: storage array has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      beat      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        m_data_q <= mem[rd_ptr];
      end
      m_valid_q <= rd_en;

      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (rd_en && !last_beat) beat <= beat + 1'b1;
      else                     beat <= '0;
    end
  end

`ifdef BLC_LINE_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_cnt;
  logic          waiting, wd_expire, timeout_err_q;

  assign waiting     = (state == WAIT_LOW) || (state == WAIT_HIGH);
  // Counter holds cycles already spent waiting; the edge that would make it TIMEOUT leaves instead.
  assign wd_expire   = waiting && (wd_cnt == WW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (!waiting || (state_next != state)) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 1'b1;
      timeout_err_q <= wd_expire;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next state defaults to the current one before the case, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start)        state_next = BURST;
      BURST:     if (last_beat)    state_next = WAIT_LOW;
      WAIT_LOW:  if (!bus.m_ready) state_next = WAIT_HIGH;
      WAIT_HIGH: if (bus.m_ready)  state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
`ifdef BLC_LINE_FEEDER_TIMEOUT_EN
    if (wd_expire) state_next = IDLE;
`endif
  end

endmodule

// File: tb/tb_blc_line_feeder.sv
// Scoreboard bench for blc_line_feeder: stimulus queues accepted pixels, a negedge monitor
// checks every emitted pixel; directed checks cover timing, holdoff, full FIFO and reset.
module tb_blc_line_feeder;

  localparam int DW         = 8;
  localparam int LINE_LEN   = 36;
  localparam int FIFO_DEPTH = 64;
  localparam int TIMEOUT    = 255;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          timeout_err;

  blc_line_feeder_if #(.DATA_WIDTH(DW)) bus ();

  blc_line_feeder #(
    .DATA_WIDTH (DW),
    .LINE_LEN   (LINE_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] mon_exp;
  int            len, lvl0, bad, n;
  logic          seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pixel presented to the correction stage must match the oldest accepted one.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid) begin
      check("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check("sb_data", bus.m_data, mon_exp);
      end
    end
  end

  task automatic write_seq(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(base + i);
      if (bus.s_ready) sb_q.push_back(DW'(base + i));
      step();
    end
    bus.s_valid = 1'b0;
  endtask

  // Waits (bounded) for m_valid, then counts consecutive valid cycles.
  task automatic measure_burst(output int blen);
    int w = 0;
    while (!bus.m_valid && w < 200) begin
      step();
      w++;
    end
    check("burst_seen", bus.m_valid, 1);
    blen = 0;
    while (bus.m_valid && blen < 200) begin
      blen++;
      step();
    end
  endtask

  task automatic handshake();
    bus.m_ready = 1'b0;
    repeat (2) step();
    bus.m_ready = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: actual=hung expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) step();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    step();

    // Basic line
    bus.m_ready = 1'b1;
    write_seq(0, LINE_LEN);
    check("basic_busy_pre", busy, 0);
    check("basic_level_full", fifo_level, LINE_LEN);
    step();
    check("basic_busy_start", busy, 1);
    check("basic_m_valid_lat", bus.m_valid, 0);
    measure_burst(len);
    check("basic_len", len, LINE_LEN);
    check("basic_level_end", fifo_level, 0);
    check("basic_busy_wait", busy, 1);
    handshake();
    check("basic_idle", busy, 0);

    // Partial line holds until the last pixel arrives
    write_seq(100, LINE_LEN - 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.m_valid || busy) seen = 1'b1;
      step();
    end
    check("partial_no_burst", seen, 0);
    check("partial_level", fifo_level, LINE_LEN - 1);
    write_seq(135, 1);
    check("partial_busy_pre", busy, 0);
    step();
    check("partial_busy_start", busy, 1);
    measure_burst(len);
    check("partial_len", len, LINE_LEN);
    handshake();

    // Concurrent fill: two lines streamed at one pixel per cycle
    fork
      write_seq(200, 2 * LINE_LEN);
      begin
        n = 0;
        while (!bus.m_valid && n < 200) begin
          step();
          n++;
        end
        check("fill_burst_seen", bus.m_valid, 1);
        lvl0 = fifo_level;
        bad  = 0;
        len  = 0;
        while (bus.m_valid && len < 200) begin
          if (len < LINE_LEN - 1 && fifo_level != LW'(lvl0)) bad++;
          len++;
          step();
        end
      end
    join
    check("fill_level_start", lvl0, LINE_LEN + 1);
    check("fill_level_const", bad, 0);
    check("fill_len", len, LINE_LEN);
    check("fill_level_after", fifo_level, LINE_LEN);

    // Holdoff: second line must wait for the m_ready low/high handshake
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid || !busy) seen = 1'b1;
      step();
    end
    bus.m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid || !busy) seen = 1'b1;
      step();
    end
    check("holdoff_no_early", seen, 0);
    bus.m_ready = 1'b1;
    step();
    check("holdoff_idle", busy, 0);
    step();
    check("holdoff_busy", busy, 1);
    check("holdoff_m_valid_lat", bus.m_valid, 0);
    step();
    check("holdoff_first_px", bus.m_valid, 1);
    measure_burst(len);
    check("holdoff_len", len, LINE_LEN);
    handshake();
    check("holdoff_level_end", fifo_level, 0);

    // Full FIFO
    bus.m_ready = 1'b0;
    write_seq(50, FIFO_DEPTH);
    check("full_level", fifo_level, FIFO_DEPTH);
    check("full_s_ready", bus.s_ready, 0);
    write_seq(238, 1);
    check("full_level_hold", fifo_level, FIFO_DEPTH);
    bus.m_ready = 1'b1;
    measure_burst(len);
    check("full_len", len, LINE_LEN);
    check("full_level_after", fifo_level, FIFO_DEPTH - LINE_LEN);
    check("full_s_ready_after", bus.s_ready, 1);

    // Reset mid-burst
    handshake();
    write_seq(120, 2 * LINE_LEN - FIFO_DEPTH);
    n = 0;
    while (!bus.m_valid && n < 200) begin
      step();
      n++;
    end
    check("rstmid_burst_seen", bus.m_valid, 1);
    repeat (9) step();
    check("rstmid_px10_valid", bus.m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_m_valid", bus.m_valid, 0);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_busy", busy, 0);
    sb_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rstmid_level_after", fifo_level, 0);
    check("rstmid_idle_after", busy, 0);
    write_seq(150, LINE_LEN);
    measure_burst(len);
    check("rstmid_new_len", len, LINE_LEN);

`ifdef BLC_LINE_FEEDER_TIMEOUT_EN
    // Watchdog: m_ready held high after the burst; pulse lands 255 cycles after entering WAIT_LOW,
    // which is TIMEOUT-1 samples after the first sample showing m_valid low.
    n = 0;
    while (!timeout_err && n < 400) begin
      step();
      n++;
    end
    check("wd_cycles", n, TIMEOUT - 1);
    check("wd_idle", busy, 0);
    step();
    check("wd_pulse_once", timeout_err, 0);
`else
    handshake();
    check("final_idle", busy, 0);
    check("final_timeout_err", timeout_err, 0);
`endif

    repeat (3) step();
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blc_line_feeder.md
# blc_line_feeder

Upstream feeder for the black-level-correction stage. It buffers raw sensor pixels in an internal FIFO. It releases exactly one complete line per burst, one pixel per cycle, and only while the correction stage reports idle. After each burst it holds off until that stage has drained its corrected line, so line N+1 never overlaps the output phase of line N.

## Interface
- DATA_WIDTH, 8, pixel width
- LINE_LEN, 36, pixels per line burst: 1 lead + 9 left black + 16 active + 9 right black + 1 trail
- FIFO_DEPTH, 64, FIFO entries; power of two, ≥ LINE_LEN
- TIMEOUT, 255, watchdog limit in cycles (only with macro)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  sensor pixel valid
- s_data  in  DATA_WIDTH  sensor pixel
- s_ready  out  1  FIFO can accept; combinational, = (level < FIFO_DEPTH)
- m_ready  in  1  correction stage idle (level signal, high = may accept a new line)
- m_valid  out  1  pixel valid to correction stage; registered
- m_data  out  DATA_WIDTH  pixel to correction stage; registered
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry (macro only; tied 0 otherwise)

## Operation
- FIFO write when s_valid && s_ready. Read only in BURST. Simultaneous write and read leave the level unchanged. A write while full is impossible because s_ready is low.
- FSM states: IDLE, BURST, WAIT_LOW, WAIT_HIGH.
  - IDLE → BURST when fifo_level ≥ LINE_LEN && m_ready.
  - BURST: pop one entry per cycle for exactly LINE_LEN cycles. m_ready is ignored. After the last pop → WAIT_LOW.
  - WAIT_LOW: wait for m_ready == 0, meaning the correction stage has started output. Then → WAIT_HIGH.
  - WAIT_HIGH: wait for m_ready == 1, meaning output is done. Then → IDLE.
- Pixels leave in arrival order. No reordering, dropping or modification.
- A burst starts only when a full line is already buffered. Sensor input may continue concurrently during the burst.
- Reset values: m_valid 0, m_data 0, busy 0, timeout_err 0, fifo_level 0, FIFO pointers 0, state IDLE.

## Timing
- Start condition sampled at edge k. First pixel appears with m_valid = 1 after edge k+1. m_valid stays high for LINE_LEN consecutive cycles, with no gaps.
- m_valid deasserts on the edge after the last pixel. State is WAIT_LOW from that cycle.
- A pixel written at edge j is counted in fifo_level after edge j. It is eligible for a start decision at edge j+1.
- m_ready falling in the same cycle as the last burst pixel is not recognised. WAIT_LOW samples m_ready from the next cycle.
- If m_ready is already low on entry to WAIT_LOW, the next edge moves to WAIT_HIGH.
- Reset asserted mid-burst: outputs clear immediately (asynchronous). FIFO contents are discarded, and the partial line is not resumed.

## Configuration
- Macro: BLC_LINE_FEEDER_TIMEOUT_EN.
- Defined: a counter runs in WAIT_LOW and WAIT_HIGH and clears on every state change. When it reaches TIMEOUT, the FSM goes to IDLE and timeout_err pulses for one cycle. FIFO contents are kept.
- Undefined: no counter, the FSM waits indefinitely, and timeout_err is tied to 0.

## Test plan
- Basic line: write 36 pixels 0..35, m_ready = 1 → m_valid high 36 consecutive cycles with m_data 0..35. busy = 1 from the start edge. fifo_level returns to 0.
- Partial line: write 35 pixels with m_ready = 1 → no m_valid. Write the 36th → burst starts on the following edge.
- Holdoff: two lines (72 pixels) buffered. After the first burst, keep m_ready high for 10 cycles, low for 20, then high → second burst starts exactly 1 cycle after m_ready returns high, never earlier.
- Concurrent fill: write continuously at 1 pixel/cycle during a burst → fifo_level constant across the burst. Second line data are intact and in order.
- Full FIFO: write 64 pixels with m_ready = 0 → s_ready = 0 at level 64. Raise m_ready → 36 pixels out, level 28, s_ready = 1.
- Reset mid-burst / watchdog: assert rst_n = 0 at burst pixel 10 → m_valid = 0 and level = 0 at once. With the macro defined and TIMEOUT = 255, hold m_ready = 1 after a burst → timeout_err pulses once, 255 cycles into WAIT_LOW, and the state returns to IDLE.
